// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and line-level constants for the UART transmitter
//
// Purpose : frame FSM state type and the fixed line levels used by uart_tx_frame.
// Ports   : none (package).
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - clearable rollover counter used for bit timing and bit indexing
//
// Purpose : counts from START_VAL to MAX_VAL while enabled, then wraps back to START_VAL.
//           The reset value is 0; clear loads START_VAL so the first counted cycle is START_VAL.
// Ports   : clk      - clock
//           n_rst    - asynchronous active-low reset
//           clear    - load START_VAL (wins over enable)
//           enable   - advance the count this cycle
//           rollover - high in the enabled cycle where the count sits at MAX_VAL
module tx_bit_timer #(
    parameter int WIDTH     = 4,
    parameter int START_VAL = 0,
    parameter int MAX_VAL   = 9
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic rollover
);

    logic [WIDTH-1:0] count;
    logic             at_max;

    assign at_max   = (count == WIDTH'(MAX_VAL));
    assign rollover = enable && at_max;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= WIDTH'(START_VAL);
        end else if (enable) begin
            if (at_max) begin
                count <= WIDTH'(START_VAL);
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter: start, LSB-first data, optional even parity, stop
//
// Purpose : serialises one DATA_BITS word per accepted tx_start onto an idle-high line.
// Ports   : clk        - clock, all state on rising edge
//           n_rst      - asynchronous active-low reset
//           tx_start   - send request, honoured only in IDLE
//           tx_data    - word to send, captured when tx_start is accepted
//           serial_out - registered serial line, idle high
//           tx_busy    - registered, high while a frame is on the line
//           tx_done    - registered, one-cycle pulse after the stop bit
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_CNT_W = $clog2(DATA_BITS + 1);

    tx_state_t            state_q, state_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic                 parity_q, parity_n;
    logic                 serial_n;
    logic                 busy_n;
    logic                 done_n;

    logic accept;
    logic bit_roll;
    logic idx_roll;

    assign accept = (state_q == IDLE) && tx_start;

    // Bit period: cycle n+1 is count 1, rollover on count CLKS_PER_BIT.
    tx_bit_timer #(
        .WIDTH     (BIT_CNT_W),
        .START_VAL (1),
        .MAX_VAL   (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (accept),
        .enable   (state_q != IDLE),
        .rollover (bit_roll)
    );

    // Data bit index: rolls over at the end of the last data bit and wraps to 0.
    tx_bit_timer #(
        .WIDTH     (IDX_CNT_W),
        .START_VAL (0),
        .MAX_VAL   (DATA_BITS - 1)
    ) u_idx_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (accept),
        .enable   ((state_q == DATA) && bit_roll),
        .rollover (idx_roll)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            serial_out <= IDLE_LEVEL;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            parity_q   <= parity_n;
            serial_out <= serial_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so every pin comes straight from a flop.
    always_comb begin
        state_n  = state_q;
        shift_n  = shift_q;
        parity_n = parity_q;
        serial_n = serial_out;
        busy_n   = tx_busy;
        done_n   = 1'b0;

        case (state_q)
            IDLE: begin
                serial_n = IDLE_LEVEL;
                busy_n   = 1'b0;
                if (tx_start) begin
                    state_n  = START;
                    shift_n  = tx_data;
                    parity_n = ^tx_data;
                    serial_n = START_BIT;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (bit_roll) begin
                    state_n  = DATA;
                    serial_n = shift_q[0];
                end
            end
            DATA: begin
                // The line always shows shift_q[0]; shift at each bit boundary.
                if (bit_roll) begin
                    shift_n = shift_q >> 1;
                    if (idx_roll) begin
                        if (PARITY_EN != 0) begin
                            state_n  = PARITY;
                            serial_n = parity_q;
                        end else begin
                            state_n  = STOP;
                            serial_n = STOP_BIT;
                        end
                    end else begin
                        serial_n = shift_n[0];
                    end
                end
            end
            PARITY: begin
                if (bit_roll) begin
                    state_n  = STOP;
                    serial_n = STOP_BIT;
                end
            end
            STOP: begin
                if (bit_roll) begin
                    state_n  = IDLE;
                    serial_n = IDLE_LEVEL;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = IDLE_LEVEL;
                busy_n   = 1'b0;
            end
        endcase
    end

endmodule
